// File: rtl/seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the iterative shift-add multiplier family:
//   - FSM state encoding and the enum type built on it
//   - operand mode encoding (unsigned / two's complement)
//   - helper for the iteration counter width
// No ports (package).
// ---------------------------------------------------------------------------
package seq_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } seq_mult_state_t;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int ctr_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_pp_step.sv
// ---------------------------------------------------------------------------
// seq_mult_pp_step
// One combinational shift-add iteration of the multiplier:
//   o_p = i_p +/- (i_mbit ? (i_mcand << i_shamt) : 0)   (mod 2^(2*WIDTH))
// Ports:
//   i_p      [2W-1:0]  running product
//   i_mcand  [2W-1:0]  extended multiplicand
//   i_mbit             current multiplier bit
//   i_shamt  [CTRW-1:0] shift amount (iteration index)
//   i_sub              1 = subtract the partial product (signed MSB step)
//   o_p      [2W-1:0]  next running product
// ---------------------------------------------------------------------------
module seq_mult_pp_step
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CTRW  = ctr_width(WIDTH),
  localparam int PW    = 2 * WIDTH
) (
  input  logic [PW-1:0]   i_p,
  input  logic [PW-1:0]   i_mcand,
  input  logic            i_mbit,
  input  logic [CTRW-1:0] i_shamt,
  input  logic            i_sub,
  output logic [PW-1:0]   o_p
);

  logic [PW-1:0] w_pp;

  always_comb begin
    w_pp = '0;
    if (i_mbit) begin
      w_pp = i_mcand << i_shamt;
    end
    // Two's complement weight of the multiplier MSB is negative, hence the
    // subtract on that step; wraparound is the intended modulo behaviour.
    if (i_sub) begin
      o_p = i_p - w_pp;
    end else begin
      o_p = i_p + w_pp;
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// ---------------------------------------------------------------------------
// seq_mult_param
// Parametrised iterative shift-add multiplier, one multiplier bit per clock,
// signed or unsigned selected per operation.
// Ports:
//   clk              clock, rising edge
//   reset            synchronous active-high reset
//   start            request, sampled only while not busy
//   is_signed        1 = two's complement operands (captured with a/b)
//   a    [W-1:0]     multiplicand
//   b    [W-1:0]     multiplier
//   p    [2W-1:0]    product, valid while rdy=1
//   busy             high while iterating
//   rdy              high from completion until next accepted start/reset
// State table:
//   S_IDLE | no result yet, waiting for start
//   S_RUN  | iterating, ctr = bit index being accumulated
//   S_DONE | result held on p, rdy=1, start may begin a new operation
// ---------------------------------------------------------------------------
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CTRW  = ctr_width(WIDTH),
  localparam int PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [PW-1:0]    p,
  output logic             busy,
  output logic             rdy
);

  localparam logic [CTRW-1:0] LAST_CTR = CTRW'(WIDTH - 1);

  seq_mult_state_t   r_state;
  logic [CTRW-1:0]   r_ctr;
  logic [PW-1:0]     r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic              r_signed;
  logic [PW-1:0]     r_p;
  logic              r_busy;
  logic              r_rdy;

  logic [PW-1:0]     w_a_ext;
  logic              w_mbit;
  logic              w_last;
  logic              w_sub;
  logic [PW-1:0]     w_p_next;

  always_comb begin
    if (is_signed == MODE_SIGNED) begin
      w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    end else begin
      w_a_ext = {{WIDTH{1'b0}}, a};
    end
  end

  // Mask-and-reduce picks bit r_ctr without an over-wide index.
  assign w_mbit = |(r_mplier & (WIDTH'(1) << r_ctr));
  assign w_last = (r_ctr == LAST_CTR);
  assign w_sub  = (r_signed == MODE_SIGNED) && w_last;

  seq_mult_pp_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_p     (r_p),
    .i_mcand (r_mcand),
    .i_mbit  (w_mbit),
    .i_shamt (r_ctr),
    .i_sub   (w_sub),
    .o_p     (w_p_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ctr    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_signed <= MODE_UNSIGNED;
      r_p      <= '0;
      r_busy   <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mcand  <= w_a_ext;
            r_mplier <= b;
            r_signed <= is_signed;
            r_p      <= '0;
            r_ctr    <= '0;
            r_busy   <= 1'b1;
            r_rdy    <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_ctr <= r_ctr + CTRW'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign p    = r_p;
  assign busy = r_busy;
  assign rdy  = r_rdy;

endmodule

// File: tb/tb_seq_mult_param.sv
module tb_seq_mult_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // WIDTH=8 instance
  logic        reset8, start8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        busy8, rdy8;

  // WIDTH=16 instance
  logic        reset16, start16, sgn16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        busy16, rdy16;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .p(p8), .busy(busy8), .rdy(rdy8)
  );

  seq_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset16), .start(start16), .is_signed(sgn16),
    .a(a16), .b(b16), .p(p16), .busy(busy16), .rdy(rdy16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic, reduced mod 2^(2w).
  function automatic logic [63:0] refp(input int w, input longint a, input longint b, input bit s);
    longint sa, sb, pr;
    sa = a;
    sb = b;
    if (s) begin
      if (((a >> (w - 1)) & 1) != 0) sa = a - (longint'(1) << w);
      if (((b >> (w - 1)) & 1) != 0) sb = b - (longint'(1) << w);
    end
    pr = sa * sb;
    return pr & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Transaction-level model: accepted start -> result after W cycles.
  bit          m8_busy = 0, m8_rdy = 0;
  logic [15:0] m8_p = '0, m8_prod = '0;
  int          m8_left = 0;
  bit          m16_busy = 0, m16_rdy = 0;
  logic [31:0] m16_p = '0, m16_prod = '0;
  int          m16_left = 0;

  always @(posedge clk) begin
    if (reset8) begin
      m8_busy = 0; m8_rdy = 0; m8_p = '0;
    end else if (m8_busy) begin
      m8_left--;
      if (m8_left == 0) begin m8_busy = 0; m8_rdy = 1; m8_p = m8_prod; end
    end else if (start8) begin
      m8_prod = 16'(refp(8, longint'(a8), longint'(b8), sgn8));
      m8_busy = 1; m8_rdy = 0; m8_p = '0; m8_left = 8;
    end
    if (reset16) begin
      m16_busy = 0; m16_rdy = 0; m16_p = '0;
    end else if (m16_busy) begin
      m16_left--;
      if (m16_left == 0) begin m16_busy = 0; m16_rdy = 1; m16_p = m16_prod; end
    end else if (start16) begin
      m16_prod = 32'(refp(16, longint'(a16), longint'(b16), sgn16));
      m16_busy = 1; m16_rdy = 0; m16_p = '0; m16_left = 16;
    end
  end

  // Every-cycle compare; p is only meaningful while not iterating.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8", busy8, m8_busy);
      chk("rdy8", rdy8, m8_rdy);
      if (!m8_busy) chk("p8", p8, m8_p);
      chk("busy16", busy16, m16_busy);
      chk("rdy16", rdy16, m16_rdy);
      if (!m16_busy) chk("p16", p16, m16_p);
    end
  end

  task automatic wait_rdy8(output int n);
    n = 0;
    while (!rdy8 && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  task automatic wait_rdy16(output int n);
    n = 0;
    while (!rdy16 && n < 60) begin @(posedge clk); #1; n++; end
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input bit s, input logic [15:0] exp);
    int n;
    @(posedge clk); #1;
    a8 = a; b8 = b; sgn8 = s; start8 = 1;
    @(posedge clk); #1;
    start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
    chk({name, "_busy"}, busy8, 1'b1);
    wait_rdy8(n);
    chk({name, "_lat"}, n, 8);
    chk(name, p8, exp);
  endtask

  task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                       input bit s, input bit has_lit, input logic [31:0] lit);
    int n;
    @(posedge clk); #1;
    a16 = a; b16 = b; sgn16 = s; start16 = 1;
    @(posedge clk); #1;
    start16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~s;
    wait_rdy16(n);
    chk({name, "_lat"}, n, 16);
    if (has_lit) chk(name, p16, lit);
    else chk(name, p16, refp(16, longint'(a), longint'(b), s));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset8 = 1; start8 = 0; sgn8 = 0; a8 = '0; b8 = '0;
    reset16 = 1; start16 = 0; sgn16 = 0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset8 = 0; reset16 = 0;
    chk_en = 1;
    chk("rst_p8", p8, 16'h0000);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_rdy8", rdy8, 1'b0);
    chk("rst_p16", p16, 32'h0);

    run8("u_3x5", 8'd3, 8'd5, 0, 16'h000F);
    run8("s_m3x5", 8'hFD, 8'd5, 1, 16'hFFF1);
    run8("s_minxmin", 8'h80, 8'h80, 1, 16'h4000);
    run8("s_minxm1", 8'h80, 8'hFF, 1, 16'h0080);
    run8("u_maxxmax", 8'hFF, 8'hFF, 0, 16'hFE01);
    run8("s_m1xm1", 8'hFF, 8'hFF, 1, 16'h0001);
    run8("u_zero_a", 8'h00, 8'hAB, 0, 16'h0000);
    run8("s_zero_b", 8'h5A, 8'h00, 1, 16'h0000);
    run8("s_maxxmin", 8'h7F, 8'h80, 1, 16'hC080);

    // Start pulsed mid-run must be ignored.
    @(posedge clk); #1;
    a8 = 8'd7; b8 = 8'd9; sgn8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'd2; b8 = 8'd2; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    wait_rdy8(n);
    chk("midrun_lat", n + 4, 8);
    chk("midrun_p", p8, 16'd63);
    // Fresh start from DONE; rdy drops on the accepting edge.
    a8 = 8'd2; b8 = 8'd2; sgn8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    chk("restart_rdy", rdy8, 1'b0);
    chk("restart_busy", busy8, 1'b1);
    wait_rdy8(n);
    chk("restart_lat", n, 8);
    chk("restart_p", p8, 16'd4);

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    a8 = 8'h55; b8 = 8'h33; sgn8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (4) @(posedge clk);
    #1;
    reset8 = 1;
    @(posedge clk); #1;
    reset8 = 0;
    chk("abort_p", p8, 16'h0000);
    chk("abort_busy", busy8, 1'b0);
    chk("abort_rdy", rdy8, 1'b0);
    // Reset together with start: stays idle.
    reset8 = 1; start8 = 1; a8 = 8'd3; b8 = 8'd3;
    @(posedge clk); #1;
    reset8 = 0; start8 = 0;
    chk("rst_start_busy", busy8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_idle_busy", busy8, 1'b0);
    chk("rst_start_idle_rdy", rdy8, 1'b0);
    chk("rst_start_idle_p", p8, 16'h0000);

    // WIDTH=16 corners with literal results.
    run16("s16_minxmin", 16'h8000, 16'h8000, 1, 1, 32'h4000_0000);
    run16("s16_minxmax", 16'h8000, 16'h7FFF, 1, 1, 32'hC000_8000);
    run16("s16_maxxmin", 16'h7FFF, 16'h8000, 1, 1, 32'hC000_8000);
    run16("s16_maxxmax", 16'h7FFF, 16'h7FFF, 1, 1, 32'h3FFF_0001);
    run16("s16_minxm1", 16'h8000, 16'hFFFF, 1, 1, 32'h0000_8000);
    run16("u16_maxxmax", 16'hFFFF, 16'hFFFF, 0, 1, 32'hFFFE_0001);

    for (int i = 0; i < 1000; i++) begin
      run16("rnd16", 16'($urandom), 16'($urandom), (i % 4) != 0, 0, 32'h0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
